accelerator_usage_vector: RTL and testbench

ACCELERATOR_USAGE_VECTOR -- requirements
Module: accelerator_usage_vector

---
 rtl/accelerator_dnc_pkg.sv | 24 ++
 rtl/accelerator_scalar_fixed_multiplier.sv | 26 ++
 rtl/accelerator_usage_vector.sv | 197 +++++++++++++++++++
 tb/tb_accelerator_usage_vector.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/accelerator_dnc_pkg.sv
// Shared definitions for the DNC accelerator blocks: FSM encoding and the
// fixed-point ZERO/ONE constants (sized down to each block's widths).
package accelerator_dnc_pkg;

    typedef enum logic [2:0] {
        STARTER = 3'd0,
        INPUT   = 3'd1,
        STEP1   = 3'd2,
        STEP2   = 3'd3,
        STEP3   = 3'd4,
        OUTPUT  = 3'd5
    } dnc_state_e;

    localparam int unsigned DNC_CONST_W = 128;

    localparam logic [DNC_CONST_W-1:0] DNC_ZERO        = 128'd0;
    localparam logic [DNC_CONST_W-1:0] DNC_CONTROL_ONE = 128'd1;

    // Fixed-point unity for a given number of fractional bits.
    function automatic logic [DNC_CONST_W-1:0] dnc_data_one(input int unsigned fraction);
        return DNC_CONTROL_ONE << fraction;
    endfunction

endpackage

// File: rtl/accelerator_scalar_fixed_multiplier.sv
// Registered unsigned fixed-point multiply: o_p = trunc((i_a * i_b) >> FRACTION).
module accelerator_scalar_fixed_multiplier #(
    parameter int DATA_SIZE = 64,
    parameter int FRACTION  = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATA_SIZE-1:0] i_a,
    input  logic [DATA_SIZE-1:0] i_b,
    output logic [DATA_SIZE-1:0] o_p
);

    logic [2*DATA_SIZE-1:0] w_full;

    assign w_full = {{DATA_SIZE{1'b0}}, i_a} * {{DATA_SIZE{1'b0}}, i_b};

    // Product register; the shifted result is truncated to the operand width.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_p <= {DATA_SIZE{1'b0}};
        end else begin
            o_p <= DATA_SIZE'(w_full >> FRACTION);
        end
    end

endmodule

// File: rtl/accelerator_usage_vector.sv
// Usage vector update u(t;j) = (u + w - u*w) * psi over j = 0..N-1, one element
// per operand handshake, results clamped to the fixed-point range [0, ONE].
module accelerator_usage_vector
    import accelerator_dnc_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int FRACTION     = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic [DATA_SIZE-1:0] SIZE_N_IN,
    input  logic [DATA_SIZE-1:0] UPREV_IN,
    input  logic                 UPREV_IN_ENABLE,
    output logic                 UPREV_OUT_ENABLE,
    input  logic [DATA_SIZE-1:0] WPREV_IN,
    input  logic                 WPREV_IN_ENABLE,
    output logic                 WPREV_OUT_ENABLE,
    input  logic [DATA_SIZE-1:0] PSI_IN,
    input  logic                 PSI_IN_ENABLE,
    output logic                 PSI_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] U_OUT,
    output logic                 U_OUT_ENABLE
);

    localparam logic [DATA_SIZE-1:0]    DATA_ZERO    = DATA_SIZE'(DNC_ZERO);
    localparam logic [DATA_SIZE-1:0]    DATA_ONE     = DATA_SIZE'(dnc_data_one(FRACTION));
    localparam logic [CONTROL_SIZE-1:0] CONTROL_ZERO = CONTROL_SIZE'(DNC_ZERO);
    localparam logic [CONTROL_SIZE-1:0] CONTROL_ONE  = CONTROL_SIZE'(DNC_CONTROL_ONE);
    localparam int SUM_W = DATA_SIZE + 2;
    localparam int CMP_W = ((DATA_SIZE > CONTROL_SIZE) ? DATA_SIZE : CONTROL_SIZE) + 1;

    // Signed saturation into [0, ONE].
    function automatic logic [DATA_SIZE-1:0] clamp_unit(input logic signed [SUM_W-1:0] v);
        logic [DATA_SIZE-1:0] res;
        if (v[SUM_W-1]) begin
            res = DATA_ZERO;
        end else if (v > $signed({2'b00, DATA_ONE})) begin
            res = DATA_ONE;
        end else begin
            res = v[DATA_SIZE-1:0];
        end
        return res;
    endfunction

    dnc_state_e               r_state, w_state_next;
    logic [DATA_SIZE-1:0]     r_size_n, r_u, r_w, r_psi, r_u_out;
    logic [CONTROL_SIZE-1:0]  r_index;
    logic                     r_flag_u, r_flag_w, r_flag_psi;
    logic                     r_ready, r_req, r_u_out_en;
    logic                     w_ready_next, w_req_next, w_u_out_en_next;
    logic                     w_flag_u, w_flag_w, w_flag_psi, w_last;
    logic [DATA_SIZE-1:0]     w_mul_a, w_mul_b, w_mul_p, w_sum_clamped;
    logic signed [SUM_W-1:0]  w_sum;

    assign w_flag_u   = r_flag_u   | UPREV_IN_ENABLE;
    assign w_flag_w   = r_flag_w   | WPREV_IN_ENABLE;
    assign w_flag_psi = r_flag_psi | PSI_IN_ENABLE;
    assign w_last     = (CMP_W'(r_index) + CMP_W'(DNC_CONTROL_ONE)) == CMP_W'(r_size_n);

    // During STEP2 the product register holds u*w, so the clamped sum is fed
    // straight back in with psi; its product lands in time for STEP3 to clamp.
    assign w_sum = $signed({2'b00, r_u}) + $signed({2'b00, r_w}) - $signed({2'b00, w_mul_p});
    assign w_sum_clamped = clamp_unit(w_sum);

    // Multiplier operand select: u*w in STEP1, s*psi in STEP2.
    always_comb begin
        w_mul_a = r_u;
        w_mul_b = r_w;
        if (r_state == STEP2) begin
            w_mul_a = w_sum_clamped;
            w_mul_b = r_psi;
        end else begin
            w_mul_a = r_u;
            w_mul_b = r_w;
        end
    end

    accelerator_scalar_fixed_multiplier #(
        .DATA_SIZE (DATA_SIZE),
        .FRACTION  (FRACTION)
    ) u_multiplier (
        .CLK (CLK),
        .RST (RST),
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .o_p (w_mul_p)
    );

    // Next-state and next pulse values.
    always_comb begin
        w_state_next    = r_state;
        w_ready_next    = 1'b0;
        w_req_next      = 1'b0;
        w_u_out_en_next = 1'b0;
        case (r_state)
            STARTER: begin
                if (START && (SIZE_N_IN != DATA_ZERO)) begin
                    w_req_next   = 1'b1;
                    w_state_next = INPUT;
                end else if (START) begin
                    w_ready_next = 1'b1;
                end else begin
                    w_state_next = STARTER;
                end
            end
            INPUT: begin
                if (w_flag_u && w_flag_w && w_flag_psi) begin
                    w_state_next = STEP1;
                end else begin
                    w_state_next = INPUT;
                end
            end
            STEP1: w_state_next = STEP2;
            STEP2: w_state_next = STEP3;
            STEP3: begin
                w_u_out_en_next = 1'b1;
                w_state_next    = OUTPUT;
            end
            OUTPUT: begin
                if (w_last) begin
                    w_ready_next = 1'b1;
                    w_state_next = STARTER;
                end else begin
                    w_req_next   = 1'b1;
                    w_state_next = INPUT;
                end
            end
            default: w_state_next = STARTER;
        endcase
    end

    // State register and registered handshake pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= STARTER;
            r_ready    <= 1'b0;
            r_req      <= 1'b0;
            r_u_out_en <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ready    <= w_ready_next;
            r_req      <= w_req_next;
            r_u_out_en <= w_u_out_en_next;
        end
    end

    // Operand capture, element indexing and result register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_size_n   <= DATA_ZERO;
            r_index    <= CONTROL_ZERO;
            r_u        <= DATA_ZERO;
            r_w        <= DATA_ZERO;
            r_psi      <= DATA_ZERO;
            r_flag_u   <= 1'b0;
            r_flag_w   <= 1'b0;
            r_flag_psi <= 1'b0;
            r_u_out    <= DATA_ZERO;
        end else begin
            case (r_state)
                STARTER: begin
                    if (START && (SIZE_N_IN != DATA_ZERO)) begin
                        r_size_n <= SIZE_N_IN;
                        r_index  <= CONTROL_ZERO;
                    end
                end
                INPUT: begin
                    if (UPREV_IN_ENABLE) r_u   <= UPREV_IN;
                    if (WPREV_IN_ENABLE) r_w   <= WPREV_IN;
                    if (PSI_IN_ENABLE)   r_psi <= PSI_IN;
                    r_flag_u   <= w_flag_u;
                    r_flag_w   <= w_flag_w;
                    r_flag_psi <= w_flag_psi;
                end
                STEP3: r_u_out <= clamp_unit($signed({2'b00, w_mul_p}));
                OUTPUT: begin
                    r_flag_u   <= 1'b0;
                    r_flag_w   <= 1'b0;
                    r_flag_psi <= 1'b0;
                    if (!w_last) r_index <= r_index + CONTROL_ONE;
                end
                default: ;
            endcase
        end
    end

    assign READY            = r_ready;
    assign UPREV_OUT_ENABLE = r_req;
    assign WPREV_OUT_ENABLE = r_req;
    assign PSI_OUT_ENABLE   = r_req;
    assign U_OUT            = r_u_out;
    assign U_OUT_ENABLE     = r_u_out_en;

endmodule

// File: tb/tb_accelerator_usage_vector.sv
// Directed bench for accelerator_usage_vector at DATA_SIZE=16, FRACTION=8 (ONE=0x0100).
module tb_accelerator_usage_vector;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        READY;
    logic [15:0] SIZE_N_IN = 16'h0000;
    logic [15:0] UPREV_IN = 16'h0000, WPREV_IN = 16'h0000, PSI_IN = 16'h0000;
    logic        UPREV_IN_ENABLE = 1'b0, WPREV_IN_ENABLE = 1'b0, PSI_IN_ENABLE = 1'b0;
    logic        UPREV_OUT_ENABLE, WPREV_OUT_ENABLE, PSI_OUT_ENABLE;
    logic [15:0] U_OUT;
    logic        U_OUT_ENABLE;

    int total = 0;
    int bad = 0;
    int n_uen = 0;
    int n_ready = 0;
    int n_req = 0;
    int base_uen, base_ready, base_req;

    accelerator_usage_vector #(
        .DATA_SIZE    (16),
        .CONTROL_SIZE (16),
        .FRACTION     (8)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .START            (START),
        .READY            (READY),
        .SIZE_N_IN        (SIZE_N_IN),
        .UPREV_IN         (UPREV_IN),
        .UPREV_IN_ENABLE  (UPREV_IN_ENABLE),
        .UPREV_OUT_ENABLE (UPREV_OUT_ENABLE),
        .WPREV_IN         (WPREV_IN),
        .WPREV_IN_ENABLE  (WPREV_IN_ENABLE),
        .WPREV_OUT_ENABLE (WPREV_OUT_ENABLE),
        .PSI_IN           (PSI_IN),
        .PSI_IN_ENABLE    (PSI_IN_ENABLE),
        .PSI_OUT_ENABLE   (PSI_OUT_ENABLE),
        .U_OUT            (U_OUT),
        .U_OUT_ENABLE     (U_OUT_ENABLE)
    );

    always #5 CLK = ~CLK;

    // Pulse counters.
    always @(posedge CLK) begin
        if (U_OUT_ENABLE) n_uen <= n_uen + 1;
        if (READY) n_ready <= n_ready + 1;
        if (UPREV_OUT_ENABLE) n_req <= n_req + 1;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_pass(input logic [15:0] n);
        START = 1'b1;
        SIZE_N_IN = n;
        tick;
        START = 1'b0;
        SIZE_N_IN = 16'h0000;
        check("req_after_start", {13'd0, UPREV_OUT_ENABLE, WPREV_OUT_ENABLE, PSI_OUT_ENABLE}, 16'h0007);
    endtask

    // mode 0: all strobes together; 1: psi first, then u+w; 2: junk u, u rewrite, then w+psi.
    task automatic element(input string tag, input logic [15:0] u, input logic [15:0] w,
                           input logic [15:0] p, input int mode, input bit poke,
                           input logic [15:0] exp, input bit last);
        if (mode == 1) begin
            PSI_IN = p; PSI_IN_ENABLE = 1'b1;
            tick;
            PSI_IN_ENABLE = 1'b0;
        end else if (mode == 2) begin
            UPREV_IN = 16'hFFFF; UPREV_IN_ENABLE = 1'b1;
            tick;
            UPREV_IN = u;
            tick;
            UPREV_IN_ENABLE = 1'b0;
        end
        UPREV_IN = u; WPREV_IN = w; PSI_IN = p;
        UPREV_IN_ENABLE = (mode != 2);
        WPREV_IN_ENABLE = 1'b1;
        PSI_IN_ENABLE = (mode != 1);
        tick;
        UPREV_IN_ENABLE = 1'b0; WPREV_IN_ENABLE = 1'b0; PSI_IN_ENABLE = 1'b0;
        if (poke) begin
            START = 1'b1; SIZE_N_IN = 16'h0000;
            UPREV_IN = 16'h0000; UPREV_IN_ENABLE = 1'b1;
        end
        check({tag, "_uen_c0"}, {15'd0, U_OUT_ENABLE}, 16'h0000);
        tick;
        START = 1'b0; UPREV_IN_ENABLE = 1'b0;
        check({tag, "_uen_c1"}, {14'd0, U_OUT_ENABLE, READY}, 16'h0000);
        tick;
        check({tag, "_uen_c2"}, {14'd0, U_OUT_ENABLE, READY}, 16'h0000);
        tick;
        check({tag, "_uen_c3"}, {14'd0, U_OUT_ENABLE, READY}, 16'h0002);
        check({tag, "_uout"}, U_OUT, exp);
        tick;
        check({tag, "_after"}, {12'd0, U_OUT_ENABLE, READY, UPREV_OUT_ENABLE, PSI_OUT_ENABLE},
              {12'd0, 1'b0, last, !last, !last});
    endtask

    initial begin
        tick;
        tick;
        check("rst_uout", U_OUT, 16'h0000);
        check("rst_pulses", {10'd0, READY, UPREV_OUT_ENABLE, WPREV_OUT_ENABLE, PSI_OUT_ENABLE,
              U_OUT_ENABLE, 1'b0}, 16'h0000);
        RST = 1'b0;
        tick;

        start_pass(16'd1);
        element("v023", 16'h0080, 16'h0080, 16'h0100, 0, 1'b0, 16'h00C0, 1'b1);
        tick;
        check("v023_ready_clear", {15'd0, READY}, 16'h0000);
        check("v023_uout_hold", U_OUT, 16'h00C0);

        start_pass(16'd1);
        element("v024", 16'h0080, 16'h0080, 16'h0080, 0, 1'b1, 16'h0060, 1'b1);
        tick;

        start_pass(16'd1);
        element("v025", 16'h0180, 16'h0000, 16'h0100, 0, 1'b0, 16'h0100, 1'b1);
        tick;

        base_uen = n_uen; base_ready = n_ready;
        start_pass(16'd3);
        element("v026_e0", 16'h0040, 16'h0040, 16'h0100, 1, 1'b0, 16'h0070, 1'b0);
        element("v026_e1", 16'h0100, 16'h0020, 16'h0080, 2, 1'b0, 16'h0080, 1'b0);
        element("v026_e2", 16'h0300, 16'h0300, 16'h0100, 1, 1'b0, 16'h0000, 1'b1);
        tick;
        check("v026_uen_count", 16'(n_uen - base_uen), 16'd3);
        check("v026_ready_count", 16'(n_ready - base_ready), 16'd1);

        base_uen = n_uen; base_ready = n_ready; base_req = n_req;
        START = 1'b1; SIZE_N_IN = 16'h0000;
        tick;
        START = 1'b0;
        check("v027_ready", {12'd0, READY, UPREV_OUT_ENABLE, WPREV_OUT_ENABLE, PSI_OUT_ENABLE}, 16'h0008);
        repeat (4) tick;
        check("v027_counts", {n_uen[3:0] - base_uen[3:0], n_ready[3:0] - base_ready[3:0],
              n_req[3:0] - base_req[3:0], 4'd0}, 16'h0100);

        base_uen = n_uen; base_ready = n_ready;
        start_pass(16'd4);
        element("v028_e0", 16'h0080, 16'h0080, 16'h0100, 0, 1'b0, 16'h00C0, 1'b0);
        UPREV_IN = 16'h0100; WPREV_IN = 16'h0100; PSI_IN = 16'h0100;
        UPREV_IN_ENABLE = 1'b1; WPREV_IN_ENABLE = 1'b1; PSI_IN_ENABLE = 1'b1;
        tick;
        UPREV_IN_ENABLE = 1'b0; WPREV_IN_ENABLE = 1'b0; PSI_IN_ENABLE = 1'b0;
        tick;
        RST = 1'b1;
        #1;
        check("v028_rst_uout", U_OUT, 16'h0000);
        check("v028_rst_pulses", {11'd0, READY, UPREV_OUT_ENABLE, WPREV_OUT_ENABLE, PSI_OUT_ENABLE,
              U_OUT_ENABLE}, 16'h0000);
        tick;
        RST = 1'b0;
        repeat (6) tick;
        check("v028_no_ready", 16'(n_ready - base_ready), 16'd0);
        check("v028_uen_count", 16'(n_uen - base_uen), 16'd1);
        start_pass(16'd1);
        element("v028_restart", 16'h0040, 16'h0040, 16'h0100, 0, 1'b0, 16'h0070, 1'b1);
        tick;
        check("v028_ready_count", 16'(n_ready - base_ready), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
